// File: rtl/fifo_reader_pkg.sv
// fifo_reader_pkg: FSM encodings and defaults shared by the FIFO reader and writer-side controllers
package fifo_reader_pkg;
  localparam int HOLD_BASE_DEF = 4;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_LATCH = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;
  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_READ  = ST_READ,
    S_LATCH = ST_LATCH,
    S_HOLD  = ST_HOLD
  } state_e;
endpackage

// File: rtl/fifo_reader_hold_timer.sv
// hold_timer: loadable down-counter that times the display hold phase
//   clk/rst : clock, synchronous active-high reset
//   load_i  : load val_i (has priority over dec_i)
//   dec_i   : decrement, saturating at zero
//   zero_o  : count is zero
module hold_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  input  logic         dec_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign zero_o = cnt_q == '0;
  always_comb cnt_d = load_i ? val_i : (dec_i && !zero_o) ? cnt_q - W'(1) : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/fifo_reader.sv
// fifo_reader: pops words from a FIFO and holds each one on a display output for a programmable time
//   clk/rst      : clock, synchronous active-high reset
//   en           : allows new pops; flush cuts the hold phase short
//   prog         : hold multiplier, hold = HOLD_BASE << prog cycles
//   fifo_empty/fifo_data/fifo_rd_en : FIFO read side, data valid one cycle after fifo_rd_en
//   data_2/data_2_valid/parity      : held word, its live flag and its XOR
//   idle/word_cnt                   : idle flag and wrapping count of captured words
//   Macro FIFO_READER_PARITY_CHECK_EN adds fifo_par input and sticky par_err output.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int HOLD_BASE = HOLD_BASE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              flush,
  input  logic [2:0]        prog,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
`ifdef FIFO_READER_PARITY_CHECK_EN
  input  logic              fifo_par,
  output logic              par_err,
`endif
  output logic              fifo_rd_en,
  output logic [DATA_W-1:0] data_2,
  output logic              data_2_valid,
  output logic              parity,
  output logic              idle,
  output logic [7:0]        word_cnt
);
  localparam int CNT_W = $clog2(HOLD_BASE + 1) + 7;
  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              latch, go, hold_zero, hold_done;
  logic [CNT_W-1:0]  hold_val;
  assign latch     = state_q == S_LATCH;
  assign go        = en & ~fifo_empty;
  assign hold_done = hold_zero | flush;
  assign hold_val  = (CNT_W'(HOLD_BASE) << prog) - CNT_W'(1);
  hold_timer #(.W(CNT_W)) u_hold (
    .clk    (clk),
    .rst    (rst),
    .load_i (latch),
    .val_i  (hold_val),
    .dec_i  (state_q == S_HOLD),
    .zero_o (hold_zero)
  );
  // A READ that finds the FIFO empty pops nothing and falls back to idle.
  always_comb begin
    state_d = state_q;
    fifo_rd_en = 1'b0;
    unique case (state_q)
      S_IDLE:  state_d = go ? S_READ : S_IDLE;
      S_READ: begin
        fifo_rd_en = ~fifo_empty;
        state_d = fifo_empty ? S_IDLE : S_LATCH;
      end
      S_LATCH: state_d = S_HOLD;
      S_HOLD:  state_d = !hold_done ? S_HOLD : go ? S_READ : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    valid_d = latch ? 1'b1 : (state_d == S_IDLE) ? 1'b0 : valid_q;
    data_d  = latch ? fifo_data : data_q;
    cnt_d   = cnt_q + 8'(latch);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end
`ifdef FIFO_READER_PARITY_CHECK_EN
  logic perr_q, perr_d;
  assign perr_d  = perr_q | (latch & (fifo_par != ^fifo_data));
  assign par_err = perr_q;
  always_ff @(posedge clk) perr_q <= rst ? 1'b0 : perr_d;
`endif
  assign data_2       = data_q;
  assign data_2_valid = valid_q;
  assign parity       = ^data_q;
  assign idle         = state_q == S_IDLE;
  assign word_cnt     = cnt_q;
endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: directed and random checks of fifo_reader against a FIFO model and capture scoreboard
module tb_fifo_reader;
  localparam int DW = 16;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, flush = 1'b0, fifo_empty = 1'b1;
  logic [2:0] prog = '0;
  logic [DW-1:0] fifo_data = '0;
  logic fifo_rd_en, data_2_valid, parity, idle;
  logic [DW-1:0] data_2;
  logic [7:0] word_cnt;
`ifdef FIFO_READER_PARITY_CHECK_EN
  logic fifo_par = 1'b0, par_err, s_perr;
`endif
  int total = 0, bad = 0;
  always #5 clk = ~clk;

  fifo_reader #(.DATA_W(DW), .HOLD_BASE(4)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .prog(prog),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data),
`ifdef FIFO_READER_PARITY_CHECK_EN
    .fifo_par(fifo_par), .par_err(par_err),
`endif
    .fifo_rd_en(fifo_rd_en), .data_2(data_2), .data_2_valid(data_2_valid),
    .parity(parity), .idle(idle), .word_cnt(word_cnt)
  );

  // FIFO contents; bit DW marks a word whose parity bit is sent corrupted
  logic [DW:0] q[$];
  typedef struct packed { int due; logic [DW-1:0] w; } cap_t;
  cap_t pend[$];
  int now = 0, last_pop = -1000, exp_cnt = 0;
  logic [DW-1:0] exp_d2 = '0;
  logic popped, s_rd, s_valid, s_idle, s_par;
  logic [DW-1:0] s_d2;
  logic [7:0] s_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [DW:0] w);
    q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // One clock: sample and score at the falling edge, then act as the FIFO after the rising edge.
  task automatic cyc();
    logic rd, rs;
    logic [DW:0] w;
    cap_t c;
    @(negedge clk);
    while (pend.size() > 0 && pend[0].due == now) begin
      c = pend.pop_front();
      exp_d2 = c.w;
      exp_cnt++;
      chk("cap_valid", data_2_valid, 1);
    end
    chk("data_2", data_2, exp_d2);
    chk("parity", parity, ^exp_d2);
    chk("word_cnt", word_cnt, exp_cnt[7:0]);
    if (idle) chk("idle_valid", data_2_valid, 0);
    popped = fifo_rd_en;
    if (fifo_rd_en) begin
      chk("rd_nonempty", fifo_empty, 0);
      chk("gap_min", (now - last_pop) >= 3, 1);
      if (q.size() > 0) pend.push_back('{now + 2, q[0][DW-1:0]});
      last_pop = now;
    end
    s_rd = fifo_rd_en; s_valid = data_2_valid; s_idle = idle; s_par = parity;
    s_d2 = data_2; s_cnt = word_cnt;
`ifdef FIFO_READER_PARITY_CHECK_EN
    s_perr = par_err;
`endif
    rd = fifo_rd_en;
    rs = rst;
    @(posedge clk);
    #1;
    if (rd && q.size() > 0) begin
      w = q.pop_front();
      fifo_data = w[DW-1:0];
`ifdef FIFO_READER_PARITY_CHECK_EN
      fifo_par = (^w[DW-1:0]) ^ w[DW];
`endif
    end
    fifo_empty = q.size() == 0;
    if (rs) begin
      pend.delete();
      exp_d2 = '0;
      exp_cnt = 0;
      last_pop = -1000;
    end
    now++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wait_pop(input int lim, output int at);
    at = -1;
    for (int i = 0; i < lim && at < 0; i++) begin
      cyc();
      if (popped) at = last_pop;
    end
    chk("pop_timeout", at >= 0, 1);
  endtask

  task automatic drain(input int lim);
    for (int i = 0; i < lim && !(q.size() == 0 && pend.size() == 0 && s_idle); i++) cyc();
    chk("drain_idle", s_idle, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, a0, a1, a2, need;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    now = 0;
    // reset state
    cyc();
    chk("rst_idle", s_idle, 1);
    chk("rst_valid", s_valid, 0);
    chk("rst_rd", s_rd, 0);
    chk("rst_par", s_par, 0);
    // first word: pop one cycle after empty falls, capture two cycles after the pop
    en = 1'b1;
    push({1'b0, 16'h00A5});
    n = now;
    wait_pop(5, a0);
    chk("lat_rd", a0, n + 1);
    cyc();
    chk("rd_pulse", s_rd, 0);
    cyc();
    chk("a5_data", s_d2, 16'h00A5);
    chk("a5_valid", s_valid, 1);
    chk("a5_par", s_par, 0);
    chk("a5_cnt", s_cnt, 1);
    run(10);
    // prog=2: pops spaced by 16 hold cycles plus READ and LATCH
    prog = 3'd2;
    push({1'b0, 16'h1111}); push({1'b0, 16'h2222}); push({1'b0, 16'h3377});
    wait_pop(5, a0); wait_pop(40, a1); wait_pop(40, a2);
    chk("gap18_a", a1 - a0, 18);
    chk("gap18_b", a2 - a1, 18);
    run(22);
    chk("hold_idle", s_idle, 1);
    chk("hold_valid", s_valid, 0);
    chk("hold_keep", s_d2, 16'h3377);
    // flush cuts every hold to a single cycle
    prog = 3'd3;
    flush = 1'b1;
    push({1'b0, 16'h4001}); push({1'b0, 16'h4002}); push({1'b0, 16'h4C03});
    wait_pop(5, a0); wait_pop(10, a1); wait_pop(10, a2);
    chk("gap_fl_a", a1 - a0, 3);
    chk("gap_fl_b", a2 - a1, 3);
    run(6);
    chk("fl_idle", s_idle, 1);
    chk("fl_valid", s_valid, 0);
    chk("fl_keep", s_d2, 16'h4C03);
    // en low blocks pops even with data waiting; flush in idle does nothing
    en = 1'b0;
    push({1'b0, 16'hBEEF});
    for (int i = 0; i < 100; i++) begin
      flush = i < 50;
      cyc();
      chk("en0_rd", s_rd, 0);
      chk("en0_idle", s_idle, 1);
    end
    en = 1'b1;
    n = now;
    wait_pop(5, a0);
    chk("en1_pop", a0, n + 1);
    // enough words to wrap word_cnt back to zero
    flush = 1'b1;
    prog = 3'd0;
    drain(200);
    need = 256 - (exp_cnt % 256);
    for (int i = 0; i < need; i++) push({1'b0, DW'($urandom)});
    drain(4000);
    chk("wrap_cnt", s_cnt, 0);
    // reset in the middle of a hold
    flush = 1'b0;
    prog = 3'd3;
    push({1'b0, 16'hF00F});
    wait_pop(5, a0);
    run(4);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    chk("mid_rst_d2", s_d2, 0);
    chk("mid_rst_valid", s_valid, 0);
    chk("mid_rst_par", s_par, 0);
    chk("mid_rst_cnt", s_cnt, 0);
    chk("mid_rst_rd", s_rd, 0);
    chk("mid_rst_idle", s_idle, 1);
`ifdef FIFO_READER_PARITY_CHECK_EN
    chk("perr_rst", s_perr, 0);
    flush = 1'b1;
    prog = 3'd0;
    push({1'b1, 16'h0001});
    for (int i = 0; i < 10; i++) push({1'b0, DW'($urandom)});
    drain(200);
    chk("perr_sticky", s_perr, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    chk("perr_clr", s_perr, 0);
`endif
    // random traffic against the scoreboard
    for (int i = 0; i < 3000; i++) begin
      en = $urandom_range(0, 9) != 0;
      flush = $urandom_range(0, 7) == 0;
      prog = 3'($urandom_range(0, 3));
      rst = $urandom_range(0, 499) == 0;
      if ($urandom_range(0, 2) == 0 && q.size() < 8) push({1'b0, DW'($urandom)});
      cyc();
    end
    rst = 1'b0;
    en = 1'b1;
    drain(2000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
